// File: rtl/fir_decim_rsat_if.sv
// Valid/ready output bus of the FIR decimate/round/saturate stage.
interface fir_decim_rsat_if #(
  parameter int OUT_W = 10
);
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (output out_data, out_valid, input out_ready);
  modport slave  (input out_data, out_valid, output out_ready);
endinterface

// File: rtl/fir_decim_rsat.sv
// Decimates the FIR output, rounds/saturates sfix20_En17 -> sfix10_En9 and
// queues results in a small FIFO with sticky saturation/overflow status.
module fir_decim_rsat #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 10,
  parameter int SHIFT = 8,
  parameter int DECIM = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_x,
  input  logic                    clk_en,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    sync_clr,
  fir_decim_rsat_if.master        out_if,
  output logic                    sat_flag,
  output logic                    ovf_flag,
  output logic [$clog2(DEPTH):0]  fill
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int RW = IN_W + 1 - SHIFT;
  localparam logic signed [IN_W:0]    HALF  = (IN_W+1)'(2**(SHIFT-1));
  localparam logic signed [RW-1:0]    R_MAX = RW'(2**(OUT_W-1) - 1);
  localparam logic signed [RW-1:0]    R_MIN = RW'(-(2**(OUT_W-1)));
  localparam logic signed [OUT_W-1:0] O_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] O_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // round-half-up: add half an output LSB one bit wider so it can't wrap
  logic signed [IN_W:0]    t_s, t_sh;
  logic signed [RW-1:0]    r_s;
  logic                    sat_hi, sat_lo;
  logic signed [OUT_W-1:0] rs_d;

  assign t_s    = $signed({in_data[IN_W-1], in_data}) + HALF;
  assign t_sh   = t_s >>> SHIFT;
  assign r_s    = t_sh[RW-1:0];
  assign sat_hi = (r_s > R_MAX);
  assign sat_lo = (r_s < R_MIN);
  assign rs_d   = sat_hi ? O_MAX : (sat_lo ? O_MIN : r_s[OUT_W-1:0]);

  logic [PW-1:0]           phase_q, phase_d;
  logic                    keep;
  logic                    st_valid_q;
  logic signed [OUT_W-1:0] st_data_q;
  logic                    sat_q, ovf_q;

  assign keep = clk_en && (phase_q == '0);

  always_comb begin
    phase_d = phase_q;
    if (clk_en) phase_d = (phase_q == PW'(DECIM-1)) ? '0 : phase_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      phase_q    <= '0;
      st_valid_q <= 1'b0;
      st_data_q  <= '0;
      sat_q      <= 1'b0;
    end else if (sync_clr) begin
      phase_q    <= '0;
      st_valid_q <= 1'b0;
      st_data_q  <= '0;
      sat_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      st_valid_q <= keep;
      if (keep) st_data_q <= rs_d;
      if (keep && (sat_hi || sat_lo)) sat_q <= 1'b1;
    end
  end

  // FIFO: extra wrap bit on pointers distinguishes full from empty
  logic signed [OUT_W-1:0] mem_q [DEPTH];
  logic [AW:0]             wptr_q, rptr_q, fill_w;
  logic                    full, empty, pop, wr, drop;

  assign fill_w = wptr_q - rptr_q;
  assign full   = (fill_w == (AW+1)'(DEPTH));
  assign empty  = (fill_w == '0);
  assign pop    = !empty && out_if.out_ready;
  // a pop in the same cycle frees the slot the pending write needs
  assign wr     = st_valid_q && (!full || pop);
  assign drop   = st_valid_q && full && !pop;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (sync_clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr) begin
        mem_q[wptr_q[AW-1:0]] <= st_data_q;
        wptr_q                <= wptr_q + (AW+1)'(1);
      end
      if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
      if (drop) ovf_q  <= 1'b1;
    end
  end

  assign out_if.out_data  = mem_q[rptr_q[AW-1:0]];
  assign out_if.out_valid = !empty;
  assign fill             = fill_w;
  assign sat_flag         = sat_q;
  assign ovf_flag         = ovf_q;
endmodule

// File: tb/tb_fir_decim_rsat.sv
// Bench: DECIM=1 (A) and DECIM=2 (B) instances on shared input, checked
// against a queue-based reference model plus directed vector tables.
module tb_fir_decim_rsat;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst_x = 1'b0, clk_en = 1'b0, sync_clr = 1'b0;
  logic signed [19:0] in_data = '0;
  logic sat_a, ovf_a, sat_b, ovf_b;
  logic [2:0] fill_a, fill_b;

  fir_decim_rsat_if #(.OUT_W(10)) ifa ();
  fir_decim_rsat_if #(.OUT_W(10)) ifb ();

  always #5 clk = ~clk;

  fir_decim_rsat #(.DECIM(1), .DEPTH(DEPTH)) u_a (
    .clk(clk), .rst_x(rst_x), .clk_en(clk_en), .in_data(in_data),
    .sync_clr(sync_clr), .out_if(ifa), .sat_flag(sat_a), .ovf_flag(ovf_a), .fill(fill_a));
  fir_decim_rsat #(.DECIM(2), .DEPTH(DEPTH)) u_b (
    .clk(clk), .rst_x(rst_x), .clk_en(clk_en), .in_data(in_data),
    .sync_clr(sync_clr), .out_if(ifb), .sat_flag(sat_b), .ovf_flag(ovf_b), .fill(fill_b));

  int n_tests = 0, n_fail = 0;

  // reference model state, index 0 = A, 1 = B
  int m_phase [2];
  bit m_stv   [2];
  int m_std   [2];
  bit m_sat   [2];
  bit m_ovf   [2];
  int m_q     [2][$];
  int popq    [2][$];
  int exq     [$];

  typedef struct { int din; int dout; int sat; } vec_t;
  vec_t rv [7];

  task automatic chk(string nm, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int d_valid(int i); return i == 0 ? int'(ifa.out_valid) : int'(ifb.out_valid); endfunction
  function automatic int d_data(int i);  return i == 0 ? int'(ifa.out_data)  : int'(ifb.out_data);  endfunction
  function automatic int d_fill(int i);  return i == 0 ? int'(fill_a) : int'(fill_b); endfunction
  function automatic int d_sat(int i);   return i == 0 ? int'(sat_a)  : int'(sat_b);  endfunction
  function automatic int d_ovf(int i);   return i == 0 ? int'(ovf_a)  : int'(ovf_b);  endfunction

  function automatic int rsat(int x, output bit s);
    int r;
    r = (x + 128) >>> 8;
    s = 1'b0;
    if (r > 511)       begin r = 511;  s = 1'b1; end
    else if (r < -512) begin r = -512; s = 1'b1; end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_stv[i] = 0; m_std[i] = 0;
      m_sat[i] = 0;   m_ovf[i] = 0; m_q[i].delete();
    end
  endtask

  task automatic model_step(int i, bit rdy);
    bit s;
    int dec;
    dec = (i == 0) ? 1 : 2;
    if (sync_clr) begin
      m_phase[i] = 0; m_stv[i] = 0; m_std[i] = 0;
      m_sat[i] = 0;   m_ovf[i] = 0; m_q[i].delete();
      return;
    end
    if (rdy && m_q[i].size() > 0) void'(m_q[i].pop_front());
    if (m_stv[i]) begin
      if (m_q[i].size() < DEPTH) m_q[i].push_back(m_std[i]);
      else m_ovf[i] = 1;
    end
    m_stv[i] = clk_en && (m_phase[i] == 0);
    if (m_stv[i]) begin
      m_std[i] = rsat(int'(in_data), s);
      if (s) m_sat[i] = 1;
    end
    if (clk_en) m_phase[i] = (m_phase[i] + 1) % dec;
  endtask

  task automatic cmp_all();
    string p;
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? "A" : "B";
      chk({p, "_valid"}, d_valid(i), int'(m_q[i].size() > 0));
      chk({p, "_fill"},  d_fill(i),  m_q[i].size());
      chk({p, "_sat"},   d_sat(i),   int'(m_sat[i]));
      chk({p, "_ovf"},   d_ovf(i),   int'(m_ovf[i]));
      if (m_q[i].size() > 0) chk({p, "_data"}, d_data(i), m_q[i][0]);
    end
  endtask

  task automatic tick();
    bit ra, rb;
    ra = ifa.out_ready;
    rb = ifb.out_ready;
    if (ifa.out_valid && ra) popq[0].push_back(d_data(0));
    if (ifb.out_valid && rb) popq[1].push_back(d_data(1));
    model_step(0, ra);
    model_step(1, rb);
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic idle(int n);
    clk_en = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear();
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    popq[0].delete();
    popq[1].delete();
  endtask

  task automatic chk_list(string nm, int i);
    chk({nm, "_count"}, popq[i].size(), exq.size());
    for (int k = 0; k < exq.size() && k < popq[i].size(); k++)
      chk($sformatf("%s_%0d", nm, k), popq[i][k], exq[k]);
  endtask

  task automatic chk_zero(string nm);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s%0d_valid", nm, i), d_valid(i), 0);
      chk($sformatf("%s%0d_data", nm, i),  d_data(i),  0);
      chk($sformatf("%s%0d_fill", nm, i),  d_fill(i),  0);
      chk($sformatf("%s%0d_sat", nm, i),   d_sat(i),   0);
      chk($sformatf("%s%0d_ovf", nm, i),   d_ovf(i),   0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rv[0] = '{4096, 16, 0};
    rv[1] = '{384, 2, 0};
    rv[2] = '{-384, -1, 0};
    rv[3] = '{-128, 0, 0};
    rv[4] = '{128, 1, 0};
    rv[5] = '{524287, 511, 1};
    rv[6] = '{-524288, -512, 1};

    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;
    model_reset();
    #2;
    chk_zero("rst");
    #10;
    rst_x = 1'b1;
    idle(2);

    // rounding / saturation table on the pass-through instance
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    foreach (rv[v]) begin
      in_data = 20'(rv[v].din);
      clk_en  = 1'b1;
      tick();
      clk_en  = 1'b0;
      chk($sformatf("lat1_valid_%0d", v), int'(ifa.out_valid), 0);
      tick();
      chk($sformatf("lat2_valid_%0d", v), int'(ifa.out_valid), 1);
      chk($sformatf("rnd_data_%0d", v),   int'(ifa.out_data), rv[v].dout);
      tick();
      chk($sformatf("sat_flag_%0d", v),   int'(sat_a), rv[v].sat);
    end
    clear();
    chk("clr_sat", int'(sat_a), 0);
    chk("clr_fill", int'(fill_a), 0);

    // decimation, clk_en every cycle
    clk_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = 20'(256 * (k + 1));
      tick();
    end
    idle(4);
    exq = {1, 3, 5};       chk_list("dec_b", 1);
    exq = {1, 2, 3, 4, 5}; chk_list("dec_a", 0);

    // decimation with gapped strobes
    clear();
    begin
      bit pat [6] = '{1, 0, 0, 1, 0, 1};
      int s = 0;
      for (int k = 0; k < 6; k++) begin
        clk_en = pat[k];
        if (pat[k]) begin s++; in_data = 20'(256 * s); end
        tick();
      end
    end
    idle(4);
    exq = {1, 3};    chk_list("gap_b", 1);
    exq = {1, 2, 3}; chk_list("gap_a", 0);

    // backpressure with overflow
    clear();
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;
    clk_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin in_data = 20'(256 * k); tick(); end
    idle(2);
    chk("bp_fill", int'(fill_a), 4);
    chk("bp_ovf",  int'(ovf_a), 1);
    chk("bp_hold", int'(ifa.out_data), 1);
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    idle(6);
    exq = {1, 2, 3, 4}; chk_list("bp_drain", 0);
    chk("bp_empty", int'(ifa.out_valid), 0);

    // full FIFO, pending write and pop in the same cycle
    clear();
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;
    clk_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin in_data = 20'(256 * k); tick(); end
    idle(2);
    chk("fp_full", int'(fill_a), 4);
    in_data = 20'(1280);
    clk_en  = 1'b1;
    tick();
    clk_en  = 1'b0;
    ifa.out_ready = 1'b1;
    tick();
    chk("fp_fill", int'(fill_a), 4);
    chk("fp_ovf",  int'(ovf_a), 0);
    idle(6);
    exq = {1, 2, 3, 4, 5}; chk_list("fp_order", 0);
    ifb.out_ready = 1'b1;
    idle(4);

    // randomized traffic against the model
    clear();
    for (int k = 0; k < 800; k++) begin
      clk_en = ($urandom % 4) != 0;
      case ($urandom % 3)
        0: in_data = 20'($urandom);
        1: in_data = 20'($signed($urandom_range(4000)) - 2000);
        default: in_data = ($urandom % 2) ? 20'(524287 - $urandom_range(300))
                                          : 20'(-524288 + $urandom_range(300));
      endcase
      ifa.out_ready = ($urandom % 3) != 0;
      ifb.out_ready = ($urandom % 2) != 0;
      sync_clr      = ($urandom % 64) == 0;
      tick();
    end
    sync_clr = 1'b0;

    // async reset mid-stream, off the clock edge
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;
    clk_en = 1'b1;
    in_data = 20'(524287); tick();
    in_data = 20'(1024);   tick();
    in_data = 20'(768);    tick();
    clk_en = 1'b0;
    tick();
    #3;
    rst_x = 1'b0;
    #1;
    chk_zero("arst");
    model_reset();
    popq[0].delete();
    popq[1].delete();
    #2;
    rst_x = 1'b1;
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    in_data = 20'(512);
    clk_en  = 1'b1;
    tick();
    clk_en  = 1'b0;
    tick();
    chk("arst_a_valid", int'(ifa.out_valid), 1);
    chk("arst_a_data",  int'(ifa.out_data), 2);
    chk("arst_b_valid", int'(ifb.out_valid), 1);
    chk("arst_b_data",  int'(ifb.out_data), 2);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_decim_rsat.md
Name: fir_decim_rsat

Overview:
- Output-conditioning stage directly downstream of the 5-tap FIR. Consumes the FIR's registered sfix20_En17 output, qualified by the shared clk_en.
- Decimates by DECIM, rounds and saturates to sfix10_En9, and buffers the result in a small FIFO.
- Presents data on a valid/ready interface to the next consumer. Overflow and saturation are reported through sticky status flags.

Parameters:
- IN_W, 20, input width (sfix20_En17).
- OUT_W, 10, output width (sfix10_En9).
- SHIFT, 8, LSBs dropped (En17 -> En9).
- DECIM, 2, decimation ratio, >=1; 1 = pass-through rate.
- DEPTH, 4, FIFO depth, power of 2, >=2.

Ports:
- clk, input, 1, single clock.
- rst_x, input, 1, asynchronous active-low reset.
- clk_en, input, 1, sample strobe; in_data valid when high.
- in_data, input, IN_W, signed sample from the FIR, sfix20_En17.
- sync_clr, input, 1, synchronous clear of phase, pipeline, FIFO and flags.
- out_data, output, OUT_W, signed sfix10_En9 at FIFO head.
- out_valid, output, 1, FIFO non-empty.
- out_ready, input, 1, consumer accepts; pop when out_valid & out_ready.
- sat_flag, output, 1, sticky; a kept sample saturated.
- ovf_flag, output, 1, sticky; a kept sample was dropped because the FIFO was full.
- fill, output, $clog2(DEPTH)+1, FIFO occupancy.

Behaviour:
- Interface: one clock, clk. Reset rst_x is asynchronous, active-low.
- Reset values: all outputs 0. Phase counter, stage register, FIFO pointers and flags are cleared.
- sync_clr has the same effect as reset, at the clock edge. It has priority over every other event in that cycle.
- Phase counter: 0..DECIM-1. Advances only when clk_en=1 and wraps DECIM-1 -> 0.
- A sample is kept when clk_en=1 and phase=0. The first clk_en after reset or clear is therefore kept. Other samples are discarded.
- Rounding: t = in_data + 2^(SHIFT-1), computed at IN_W+1 bits. r = t >>> SHIFT (arithmetic shift). This is round-half-up toward +inf.
- Saturation: if r > 2^(OUT_W-1)-1, output 511 and set sat_flag. If r < -2^(OUT_W-1), output -512 and set sat_flag. Otherwise output r[OUT_W-1:0].
- Stage register: the kept sample is captured at edge N, together with st_valid.
- FIFO write: occurs at edge N+1 when st_valid=1.
  - out_valid rises after edge N+1, giving 2-cycle latency from the input edge to out_valid.
- FIFO head: out_data comes from registered storage, selected by the read pointer. out_data holds its value while out_valid=1 and out_ready=0.
- Pop: out_valid & out_ready at an edge advances the read pointer. Pop when empty is ignored. out_ready is don't-care when out_valid=0.
- Full FIFO with a write pending:
  - If a pop occurs in the same cycle, the write proceeds and fill is unchanged.
  - Otherwise the sample is dropped, ovf_flag is set, and the FIFO is unchanged.
- Simultaneous push and pop when empty: push only. The FIFO is not bypassed, and the data appears next cycle.
- fill: pointer difference using an extra wrap bit. Full is fill==DEPTH; empty is fill==0.
- Sticky flags: cleared only by reset or sync_clr. A set event in the same cycle as sync_clr loses to the clear.
- clk_en=0 stalls only the input side (phase counter). The FIFO still writes pending st_valid and still pops.
- Reset mid-operation: in-flight and buffered samples are lost. No output glitch beyond the asynchronous clear to 0.

Test Plan:
- Round: DECIM=1, out_ready=1, inputs 4096, 384, -384, -128, 128 -> out_data 16, 2, -1, 0, 1. out_valid 2 cycles after each input. sat_flag=0.
- Saturation: inputs 20'h7FFFF then 20'h80000 -> out_data 511 then -512. sat_flag=1 after the first and stays 1. sync_clr pulse -> sat_flag=0 and fill=0.
- Decimation: DECIM=2, clk_en every cycle, inputs 256,512,768,1024,1280 -> outputs 1,3,5.
  - clk_en gapped (1,0,0,1,0,1) with the same data -> kept samples are the 1st and 3rd strobes only.
- Backpressure/overflow: DEPTH=4, out_ready=0, 6 kept samples 256..1536 -> fill=4, ovf_flag=1. out_data holds 1. Release out_ready -> outputs 1,2,3,4, then out_valid=0.
- Full with simultaneous pop: FIFO full, write pending and out_ready=1 in the same cycle -> fill stays 4, ovf_flag stays 0, order preserved.
- Async reset: assert rst_x=0 mid-stream, unaligned to clk -> all outputs 0 immediately. After release, the first clk_en sample is kept (phase restarts at 0).
